dbg_slave_sysclk_cmdq: RTL and testbench

- System-clock half of the CPU debug slave, generalised.
- Takes the JTAG-domain instruction register (ir_in), data shift register (sr) and the update-IR/update-DR strobes. Synchronises the strobes into clk and captures ir/sr on their edges.
- Queues each completed DR update as a command {channel, data, action} in a FIFO. Commands are delivered to the CPU-side OCI logic over a valid/ready handshake instead of single-cycle take_action pulses, so back-to-back JTAG updates are never silently lost.

---
 rtl/dbg_slave_sysclk_cmdq_if.sv | 15 +
 rtl/dbg_slave_sysclk_cmdq.sv | 143 ++++++++++++++
 tb/tb_dbg_slave_sysclk_cmdq.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_slave_sysclk_cmdq_if.sv
// Command handshake between the debug-slave command queue (master) and the
// CPU-side OCI logic (slave).
interface dbg_slave_sysclk_cmdq_if #(
  parameter int IR_W = 2,
  parameter int DR_W = 38
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ch;
  logic [DR_W-1:0] cmd_data;
  logic            cmd_action;

  modport master (output cmd_valid, cmd_ch, cmd_data, cmd_action, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ch, cmd_data, cmd_action, output cmd_ready);
endinterface

// File: rtl/dbg_slave_sysclk_cmdq.sv
// System-clock half of the debug slave: synchronises JTAG update strobes and
// queues DR updates as commands. Optional parity check: DBG_CMDQ_PARITY_EN.
module dbg_slave_sysclk_cmdq #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int ACT_BIT     = 35,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [DR_W-1:0]               sr,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  dbg_slave_sysclk_cmdq_if.master       cmd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow
`ifdef DBG_CMDQ_PARITY_EN
  ,
  input  logic                          sr_par,
  output logic                          parity_err
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

  typedef struct packed {
    logic [IR_W-1:0] ch;
    logic [DR_W-1:0] data;
  } cmd_t;

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                   udr_hist, uir_hist;
  logic                   udr_edge, uir_edge;
  logic [IR_W-1:0]        ir_reg;

  cmd_t                   mem [FIFO_DEPTH];
  cmd_t                   head;
  cmd_t                   push_cmd;
  logic                   head_valid;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr, rd_ptr_inc;
  logic [LVL_W-1:0]       level_q, level_next;
  logic                   par_ok, push_req, push, pop, full, drop;

  // Edge pulses are registered, so the push lands one cycle after detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_hist <= 1'b0;
      uir_hist <= 1'b0;
      udr_edge <= 1'b0;
      uir_edge <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_hist <= udr_sync[SYNC_STAGES-1];
      uir_hist <= uir_sync[SYNC_STAGES-1];
      udr_edge <= udr_sync[SYNC_STAGES-1] & ~udr_hist;
      uir_edge <= uir_sync[SYNC_STAGES-1] & ~uir_hist;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ir_reg <= '0;
    else if (uir_edge) ir_reg <= ir_in;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    push_cmd   = '{ch: ir_reg, data: sr};
`ifdef DBG_CMDQ_PARITY_EN
    par_ok     = ~(^{sr, ir_reg, sr_par});
`else
    par_ok     = 1'b1;
`endif
    push_req   = udr_edge & par_ok;
    pop        = head_valid & cmd.cmd_ready;
    full       = (level_q == FULL_LVL);
    push       = push_req & (~full | pop);
    drop       = push_req & full & ~pop;
    rd_ptr_inc = rd_ptr + 1'b1;
    level_next = level_q;
    if (push && !pop)      level_next = level_q + 1'b1;
    else if (pop && !push) level_next = level_q - 1'b1;
  end

  // NOTE: the storage array has no reset; validity is carried by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_cmd;
  end

  // Head register: refilled from storage on pop, or straight from the push
  // when the pushed entry becomes the head in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_inc;
      level_q    <= level_next;
      head_valid <= (level_next != '0);
      if (pop) begin
        if (level_q > ONE_LVL) head <= mem[rd_ptr_inc];
        else if (push)         head <= push_cmd;
      end else if (!head_valid && push) begin
        head <= push_cmd;
      end
    end
  end

  // Sticky flags: a new event in the same cycle as the clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

`ifdef DBG_CMDQ_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  parity_err <= 1'b0;
    else if (udr_edge && !par_ok)  parity_err <= 1'b1;
    else if (clr_overflow)         parity_err <= 1'b0;
  end
`endif

  assign cmd.cmd_valid  = head_valid;
  assign cmd.cmd_ch     = head.ch;
  assign cmd.cmd_data   = head.data;
  assign cmd.cmd_action = head.data[ACT_BIT];
  assign fifo_level     = level_q;

endmodule

// File: tb/tb_dbg_slave_sysclk_cmdq.sv
// Self-checking bench for dbg_slave_sysclk_cmdq: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_dbg_slave_sysclk_cmdq;

  localparam int IR_W  = 2;
  localparam int DR_W  = 38;
  localparam int ACT   = 35;
  localparam int S     = 2;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [IR_W-1:0] ch;
    logic [DR_W-1:0] data;
  } ent_t;

  logic             clk;
  logic             reset_n;
  logic [IR_W-1:0]  ir_in;
  logic [DR_W-1:0]  sr;
  logic             vs_udr, vs_uir;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             clr_overflow;
`ifdef DBG_CMDQ_PARITY_EN
  logic             sr_par;
  logic             parity_err;
`endif

  int total = 0;
  int bad   = 0;
  logic [IR_W-1:0] exp_ir;

  dbg_slave_sysclk_cmdq_if #(.IR_W(IR_W), .DR_W(DR_W)) cmd_if ();

  dbg_slave_sysclk_cmdq #(
    .IR_W(IR_W), .DR_W(DR_W), .ACT_BIT(ACT), .SYNC_STAGES(S), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ir_in        (ir_in),
    .sr           (sr),
    .vs_udr       (vs_udr),
    .vs_uir       (vs_uir),
    .cmd          (cmd_if),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef DBG_CMDQ_PARITY_EN
    ,
    .sr_par       (sr_par),
    .parity_err   (parity_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_udr(input logic [DR_W-1:0] d);
    sr = d;
`ifdef DBG_CMDQ_PARITY_EN
    sr_par = ^{d, exp_ir};
`endif
    vs_udr = 1'b1;
  endtask

  // Six-cycle udr pulse; the push lands S+2 edges after the rise.
  task automatic udr_pulse(input logic [DR_W-1:0] d);
    drive_udr(d);
    tick(2);
    vs_udr = 1'b0;
    tick(4);
  endtask

  task automatic uir_pulse(input logic [IR_W-1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    tick(2);
    vs_uir = 1'b0;
    tick(4);
    exp_ir = v;
  endtask

  task automatic pop_one;
    cmd_if.cmd_ready = 1'b1;
    tick(1);
    cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
    clr_overflow = 1'b0; cmd_if.cmd_ready = 1'b0; exp_ir = '0;
`ifdef DBG_CMDQ_PARITY_EN
    sr_par = 1'b0;
`endif
    tick(3);
    total++;
    if (cmd_if.cmd_valid !== 1'b0 || cmd_if.cmd_ch !== '0 || cmd_if.cmd_action !== 1'b0) begin
      bad++;
      $display("FAIL reset_head got valid=%b ch=%0d act=%b exp 0/0/0",
               cmd_if.cmd_valid, cmd_if.cmd_ch, cmd_if.cmd_action);
    end
    total++;
    if (cmd_if.cmd_data !== '0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", cmd_if.cmd_data);
    end
    total++;
    if (fifo_level !== '0 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_level got level=%0d ovf=%b exp 0/0", fifo_level, overflow);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic;
    uir_pulse(2'd1);
    drive_udr(38'h08_0000_1234);
    tick(S + 1);
    total++;
    if (cmd_if.cmd_valid !== 1'b0) begin
      bad++; $display("FAIL basic_early got valid=%b exp=0", cmd_if.cmd_valid);
    end
    tick(1);
    total++;
    if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_ch !== 2'd1 || cmd_if.cmd_action !== 1'b1) begin
      bad++;
      $display("FAIL basic_head got valid=%b ch=%0d act=%b exp 1/1/1",
               cmd_if.cmd_valid, cmd_if.cmd_ch, cmd_if.cmd_action);
    end
    total++;
    if (cmd_if.cmd_data !== 38'h08_0000_1234 || fifo_level !== LVL_W'(1)) begin
      bad++;
      $display("FAIL basic_data got data=%h level=%0d exp 0800001234/1", cmd_if.cmd_data, fifo_level);
    end
    vs_udr = 1'b0;
    pop_one();
    total++;
    if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== '0) begin
      bad++; $display("FAIL basic_pop got valid=%b level=%0d exp 0/0", cmd_if.cmd_valid, fifo_level);
    end
    tick(3);
  endtask

  task automatic drain_expect(input string name, input logic [DR_W-1:0] first, input int n);
    cmd_if.cmd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      total++;
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_data !== first + DR_W'(i) || cmd_if.cmd_ch !== exp_ir) begin
        bad++;
        $display("FAIL %s_drain%0d got valid=%b data=%h ch=%0d exp 1/%h/%0d", name, i,
                 cmd_if.cmd_valid, cmd_if.cmd_data, cmd_if.cmd_ch, first + DR_W'(i), exp_ir);
      end
      tick(1);
    end
    cmd_if.cmd_ready = 1'b0;
    total++;
    if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== '0) begin
      bad++;
      $display("FAIL %s_empty got valid=%b level=%0d exp 0/0", name, cmd_if.cmd_valid, fifo_level);
    end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 5; i++) udr_pulse(DR_W'(i));
    total++;
    if (fifo_level !== LVL_W'(DEPTH) || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_full got level=%0d ovf=%b exp 4/1", fifo_level, overflow);
    end
    drain_expect("ovf", DR_W'(1), 4);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%b exp=0", overflow);
    end
  endtask

  task automatic test_full_pop;
    for (int i = 0; i < 4; i++) udr_pulse(DR_W'(16 + i));
    drive_udr(DR_W'(20));
    for (int i = 1; i <= S + 2; i++) begin
      if (i == S + 2) cmd_if.cmd_ready = 1'b1;
      tick(1);
      if (i == 2) vs_udr = 1'b0;
    end
    cmd_if.cmd_ready = 1'b0;
    total++;
    if (fifo_level !== LVL_W'(DEPTH) || overflow !== 1'b0) begin
      bad++; $display("FAIL fullpop_level got level=%0d ovf=%b exp 4/0", fifo_level, overflow);
    end
    tick(2);
    drain_expect("fullpop", DR_W'(17), 4);
  endtask

  task automatic test_simul_edges;
    uir_pulse(2'd0);
    ir_in  = 2'd3;
    vs_uir = 1'b1;
    drive_udr(DR_W'('h2A));
    tick(2);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    tick(4);
    total++;
    if (cmd_if.cmd_ch !== 2'd0 || cmd_if.cmd_data !== DR_W'('h2A) || fifo_level !== LVL_W'(1)) begin
      bad++;
      $display("FAIL simul_old_ir got ch=%0d data=%h level=%0d exp 0/2a/1",
               cmd_if.cmd_ch, cmd_if.cmd_data, fifo_level);
    end
    exp_ir = 2'd3;
    pop_one();
    udr_pulse(DR_W'('h3B));
    total++;
    if (cmd_if.cmd_ch !== 2'd3 || cmd_if.cmd_data !== DR_W'('h3B)) begin
      bad++; $display("FAIL simul_new_ir got ch=%0d data=%h exp 3/3b", cmd_if.cmd_ch, cmd_if.cmd_data);
    end
    pop_one();
  endtask

  task automatic test_held_high;
    drive_udr(DR_W'('h55));
    tick(20);
    vs_udr = 1'b0;
    tick(4);
    total++;
    if (fifo_level !== LVL_W'(1) || cmd_if.cmd_data !== DR_W'('h55)) begin
      bad++; $display("FAIL held_one got level=%0d data=%h exp 1/55", fifo_level, cmd_if.cmd_data);
    end
    pop_one();
    for (int i = 0; i < 4; i++) udr_pulse(DR_W'('h60 + i));
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL clrwin_pre got ovf=%b exp=0", overflow);
    end
    drive_udr(DR_W'('h64));
    for (int i = 1; i <= S + 2; i++) begin
      if (i == S + 2) clr_overflow = 1'b1;
      tick(1);
      if (i == 2) vs_udr = 1'b0;
    end
    clr_overflow = 1'b0;
    total++;
    if (overflow !== 1'b1 || fifo_level !== LVL_W'(DEPTH)) begin
      bad++; $display("FAIL clrwin_set got ovf=%b level=%0d exp 1/4", overflow, fifo_level);
    end
    tick(2);
    drain_expect("clrwin", DR_W'('h60), 4);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) udr_pulse(DR_W'('h71 + i));
    total++;
    if (fifo_level !== LVL_W'(3)) begin
      bad++; $display("FAIL rstmid_pre got level=%0d exp=3", fifo_level);
    end
    drive_udr(DR_W'('h74));
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== '0) begin
      bad++; $display("FAIL rstmid_async got valid=%b level=%0d exp 0/0", cmd_if.cmd_valid, fifo_level);
    end
    vs_udr = 1'b0;
    tick(2);
    reset_n = 1'b1;
    exp_ir = '0;
    tick(8);
    total++;
    if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== '0) begin
      bad++; $display("FAIL rstmid_inflight got valid=%b level=%0d exp 0/0", cmd_if.cmd_valid, fifo_level);
    end
    udr_pulse(DR_W'('h75));
    total++;
    if (cmd_if.cmd_ch !== 2'd0 || cmd_if.cmd_data !== DR_W'('h75)) begin
      bad++; $display("FAIL rstmid_irreg got ch=%0d data=%h exp 0/75", cmd_if.cmd_ch, cmd_if.cmd_data);
    end
    pop_one();
  endtask

  task automatic test_parity;
`ifdef DBG_CMDQ_PARITY_EN
    sr = DR_W'(1);
    sr_par = 1'b0;
    vs_udr = 1'b1;
    tick(2);
    vs_udr = 1'b0;
    tick(4);
    total++;
    if (fifo_level !== '0 || parity_err !== 1'b1) begin
      bad++; $display("FAIL parity_drop got level=%0d perr=%b exp 0/1", fifo_level, parity_err);
    end
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    total++;
    if (parity_err !== 1'b0) begin
      bad++; $display("FAIL parity_clear got=%b exp=0", parity_err);
    end
`endif
  endtask

  // Random slots of six cycles; the model applies pushes S+2 edges after the
  // strobe rise and pops whenever it holds an entry and ready was driven.
  task automatic test_random;
    ent_t q[$];
    logic exp_ovf = 1'b0;
    for (int slot = 0; slot < 80; slot++) begin
      logic do_udr = ($urandom_range(0, 99) < 80);
      logic do_uir = ($urandom_range(0, 99) < 30);
      logic [IR_W-1:0] new_ir = IR_W'($urandom_range(0, 3));
      logic [DR_W-1:0] d = DR_W'({$urandom(), $urandom()});
      int rate = (slot < 40) ? 20 : 75;
      if (do_uir) begin
        ir_in  = new_ir;
        vs_uir = 1'b1;
      end
      if (do_udr) drive_udr(d);
      for (int c = 1; c <= 6; c++) begin
        logic pop;
        cmd_if.cmd_ready = ($urandom_range(0, 99) < rate);
        pop = (q.size() != 0) && cmd_if.cmd_ready;
        tick(1);
        if (pop) void'(q.pop_front());
        if (do_udr && c == S + 2) begin
          if (q.size() == DEPTH) exp_ovf = 1'b1;
          else q.push_back('{ch: exp_ir, data: d});
        end
        if (do_uir && c == S + 2) exp_ir = new_ir;
        if (c == 2) begin
          vs_udr = 1'b0;
          vs_uir = 1'b0;
        end
        total++;
        if (fifo_level !== LVL_W'(q.size()) || cmd_if.cmd_valid !== (q.size() != 0) || overflow !== exp_ovf) begin
          bad++;
          $display("FAIL rand_state slot=%0d c=%0d got level=%0d valid=%b ovf=%b exp %0d/%b/%b",
                   slot, c, fifo_level, cmd_if.cmd_valid, overflow, q.size(), q.size() != 0, exp_ovf);
        end
        if (q.size() != 0) begin
          total++;
          if (cmd_if.cmd_ch !== q[0].ch || cmd_if.cmd_data !== q[0].data ||
              cmd_if.cmd_action !== q[0].data[ACT]) begin
            bad++;
            $display("FAIL rand_head slot=%0d c=%0d got ch=%0d data=%h act=%b exp %0d/%h/%b",
                     slot, c, cmd_if.cmd_ch, cmd_if.cmd_data, cmd_if.cmd_action,
                     q[0].ch, q[0].data, q[0].data[ACT]);
          end
        end
      end
    end
    cmd_if.cmd_ready = 1'b1;
    tick(6);
    cmd_if.cmd_ready = 1'b0;
    total++;
    if (fifo_level !== '0) begin
      bad++; $display("FAIL rand_drain got level=%0d exp=0", fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_simul_edges();
    test_held_high();
    test_reset_mid();
    test_parity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
